seq3_stream_ctrl: RTL and testbench

//  - Sequencer for the three-consecutive-ones serial detector datapath.
//  - Accepts a parallel WIDTH-bit word over a start/ready handshake and shifts it LSB-first, one bit per clock, into an embedded detector.
//  - Counts detections per word and records the bit index of the first detection; reports results with a done pulse.
//  - Sits between a word producer (bus/regfile) and the detector, replacing testbench-driven bit feeding.

---
 rtl/seq3_pkg.sv | 17 +
 rtl/seq3_det.sv | 36 +++
 rtl/seq3_stream_ctrl.sv | 125 ++++++++++++
 tb/tb_seq3_stream_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seq3_pkg.sv
// Shared constants and state encoding for the three-ones stream sequencer.
package seq3_pkg;

   localparam int unsigned WIDTH_DEF = 16;
   localparam int unsigned CNT_W_DEF = $clog2(WIDTH_DEF + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT,
      S_DONE  = ST_DONE
   } state_e;

endpackage

// File: rtl/seq3_det.sv
// Three-consecutive-ones detector: two-bit history plus a combinational match.
module seq3_det
   import seq3_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic vld,
   input  logic din,
   output logic match
);

   logic [1:0] hist_q;
   logic [1:0] hist_d;

   always_comb begin
      hist_d = hist_q;
      if (clr) begin
         hist_d = 2'b00;
      end else if (vld) begin
         hist_d = {hist_q[0], din};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q <= 2'b00;
      end else begin
         hist_q <= hist_d;
      end
   end

   // hist_q[0] is the previous bit, hist_q[1] the one before it
   assign match = vld & din & hist_q[0] & hist_q[1];

endmodule

// File: rtl/seq3_stream_ctrl.sv
// Word-to-bit sequencer feeding seq3_det; counts matches per word.
// Build option: define DET_CARRY_EN to keep detector history across words.
module seq3_stream_ctrl
   import seq3_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] word,
   output logic             ready,
   output logic             busy,
   output logic             bit_out,
   output logic             bit_vld,
   output logic             match,
   output logic             done,
   output logic [CNT_W-1:0] match_cnt,
   output logic [CNT_W-1:0] first_idx,
   output logic             found
);

   state_e             state_q,  state_d;
   logic [WIDTH-1:0]   sreg_q,   sreg_d;
   logic [CNT_W-1:0]   idx_q,    idx_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [CNT_W-1:0]   first_q,  first_d;
   logic               found_q,  found_d;

   logic start_acc;
   logic shifting;
   logic det_clr;
   logic det_match;

   assign start_acc = (state_q == S_IDLE) & start;
   assign shifting  = (state_q == S_SHIFT);

`ifdef DET_CARRY_EN
   assign det_clr = 1'b0;
`else
   assign det_clr = start_acc;
`endif

   seq3_det u_det (
      .clk   (clk),
      .rst   (rst),
      .clr   (det_clr),
      .vld   (shifting),
      .din   (shifting & sreg_q[0]),
      .match (det_match)
   );

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      found_d = found_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SHIFT;
               sreg_d  = word;
               idx_d   = '0;
               cnt_d   = '0;
               first_d = '0;
               found_d = 1'b0;
            end
         end
         S_SHIFT: begin
            sreg_d = sreg_q >> 1;
            idx_d  = idx_q + CNT_W'(1);
            if (det_match) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (!found_q) begin
                  first_d = idx_q;
                  found_d = 1'b1;
               end
            end
            if (idx_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         sreg_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         first_q <= '0;
         found_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         found_q <= found_d;
      end
   end

   // Status outputs are decodes of the state flop; match follows bit_out
   assign ready     = (state_q == S_IDLE);
   assign busy      = shifting;
   assign bit_vld   = shifting;
   assign bit_out   = shifting & sreg_q[0];
   assign match     = det_match;
   assign done      = (state_q == S_DONE);
   assign match_cnt = cnt_q;
   assign first_idx = first_q;
   assign found     = found_q;

endmodule

// File: tb/tb_seq3_stream_ctrl.sv
// Directed self-checking bench for seq3_stream_ctrl (WIDTH=16).
module tb_seq3_stream_ctrl;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned CNT_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] word;
   logic             ready;
   logic             busy;
   logic             bit_out;
   logic             bit_vld;
   logic             match;
   logic             done;
   logic [CNT_W-1:0] match_cnt;
   logic [CNT_W-1:0] first_idx;
   logic             found;

   int checks   = 0;
   int failures = 0;

   seq3_stream_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .word      (word),
      .ready     (ready),
      .busy      (busy),
      .bit_out   (bit_out),
      .bit_vld   (bit_vld),
      .match     (match),
      .done      (done),
      .match_cnt (match_cnt),
      .first_idx (first_idx),
      .found     (found)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Feed one word; mmask holds the hand-derived match positions.
   // inject >= 0 pulses start with a different word during that SHIFT cycle.
   task automatic run_word(input string name, input logic [15:0] w, input logic [15:0] mmask,
                           input int ecnt, input int efirst, input int inject);
      chk({name, ".ready"}, 32'(ready), 32'd1);
      start = 1'b1;
      word  = w;
      step();
      start = 1'b0;
      word  = 16'hA5A5;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("%s.busy%0d", name, i),  32'(busy),    32'd1);
         chk($sformatf("%s.vld%0d", name, i),   32'(bit_vld), 32'd1);
         chk($sformatf("%s.bit%0d", name, i),   32'(bit_out), 32'(w[i]));
         chk($sformatf("%s.match%0d", name, i), 32'(match),   32'(mmask[i]));
         chk($sformatf("%s.done%0d", name, i),  32'(done),    32'd0);
         if (i == inject) begin
            start = 1'b1;
            word  = 16'hFFFF;
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
      chk({name, ".done"},  32'(done),      32'd1);
      chk({name, ".cnt"},   32'(match_cnt), 32'(ecnt));
      chk({name, ".first"}, 32'(first_idx), 32'(efirst));
      chk({name, ".found"}, 32'(found),     32'(ecnt != 0));
      chk({name, ".match_done"}, 32'(match), 32'd0);
      step();
      chk({name, ".done_clr"}, 32'(done),      32'd0);
      chk({name, ".idle"},     32'(ready),     32'd1);
      chk({name, ".bit_idle"}, 32'(bit_out),   32'd0);
      chk({name, ".cnt_hold"}, 32'(match_cnt), 32'(ecnt));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int extra;
      rst   = 1'b0;
      start = 1'b0;
      word  = '0;
      #1;
      chk("rst.ready", 32'(ready),     32'd1);
      chk("rst.busy",  32'(busy),      32'd0);
      chk("rst.vld",   32'(bit_vld),   32'd0);
      chk("rst.bit",   32'(bit_out),   32'd0);
      chk("rst.match", 32'(match),     32'd0);
      chk("rst.done",  32'(done),      32'd0);
      chk("rst.cnt",   32'(match_cnt), 32'd0);
      chk("rst.first", 32'(first_idx), 32'd0);
      chk("rst.found", 32'(found),     32'd0);
      step();
      step();
      rst = 1'b1;
      step();

      run_word("zero", 16'h0000, 16'h0000, 0, 0, -1);
      run_word("mix",  16'b0101_0111_0111_0011, 16'h0440, 2, 6, -1);
      run_word("ones", 16'hFFFF, 16'hFFFC, 14, 2, -1);
      run_word("hiC0", 16'hC000, 16'h0000, 0, 0, -1);
`ifdef DET_CARRY_EN
      run_word("carry", 16'h0001, 16'h0001, 1, 0, -1);
`else
      run_word("carry", 16'h0001, 16'h0000, 0, 0, -1);
`endif

      // start pulse mid-word must be dropped, giving exactly one done
      run_word("ctl", 16'h0007, 16'h0004, 1, 2, 5);
      extra = 0;
      repeat (20) begin
         if (done || busy) extra++;
         step();
      end
      chk("ctl.no_queue", 32'(extra), 32'd0);

      // asynchronous reset at SHIFT cycle 8 aborts the word
      chk("abort.ready", 32'(ready), 32'd1);
      start = 1'b1;
      word  = 16'hFFFF;
      step();
      start = 1'b0;
      repeat (8) step();
      chk("abort.busy_pre", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      chk("abort.ready", 32'(ready),     32'd1);
      chk("abort.busy",  32'(busy),      32'd0);
      chk("abort.vld",   32'(bit_vld),   32'd0);
      chk("abort.bit",   32'(bit_out),   32'd0);
      chk("abort.match", 32'(match),     32'd0);
      chk("abort.done",  32'(done),      32'd0);
      chk("abort.cnt",   32'(match_cnt), 32'd0);
      chk("abort.first", 32'(first_idx), 32'd0);
      chk("abort.found", 32'(found),     32'd0);
      step();
      rst = 1'b1;
      extra = 0;
      repeat (20) begin
         if (done || busy) extra++;
         step();
      end
      chk("abort.no_done", 32'(extra), 32'd0);

      run_word("post", 16'h0007, 16'h0004, 1, 2, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
